record_playback_packer: RTL and testbench

RECORD_PLAYBACK_PACKER -- requirements
Module: record_playback_packer

---
 rtl/packer_pkg.sv | 15 +
 rtl/packer_bit_counter.sv | 23 ++
 rtl/record_playback_packer.sv | 176 +++++++++++++++++
 tb/tb_record_playback_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// Shared types and widths for the record/playback bit packer.
// Holds the FSM state encoding and word/bit-count widths.
package packer_pkg;

  localparam int WORD_W   = 32;
  localparam int BITCNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FETCH  = 2'd2,
    PLAY   = 2'd3
  } state_t;

endpackage

// File: rtl/packer_bit_counter.sv
// 5-bit up-counter with synchronous clear and enable; wraps 31->0.
// Ports: clk, reset (sync, active-low), clr, en, count.
module packer_bit_counter
  import packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  output logic [BITCNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/record_playback_packer.sv
// Records serial bits into 32-bit words (MSB first) and plays them back.
// Ports: clk, reset (sync active-low), Rec_butt, Play_butt, bit_en, bit_in,
//   mem_we/mem_addr/mem_wdata/mem_rdata (1-cycle read latency),
//   bit_out, bit_out_valid, state, rec_len, full.
// Macro PACKER_LOOP_PLAY_EN: when defined, playback restarts at word 0
//   after the last word until a button is pressed.
module record_playback_packer
  import packer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Rec_butt,
  input  logic                Play_butt,
  input  logic                bit_en,
  input  logic                bit_in,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                bit_out,
  output logic                bit_out_valid,
  output logic [1:0]          state,
  output logic [ADDR_W:0]     rec_len,
  output logic                full
);

  localparam int            DEPTH_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST  = DEPTH - 1'b1;
  localparam logic [BITCNT_W-1:0] CNT_LAST = '1;

  state_t              st;
  logic [ADDR_W:0]     wptr;
  logic [ADDR_W:0]     rptr;
  logic [ADDR_W:0]     wnext;
  logic [ADDR_W:0]     rnext;
  logic [WORD_W-1:0]   shreg;
  logic                wr_pend;
  logic                fetch_ph;
  logic                btn;
  logic                cnt_clr;
  logic                cnt_en;
  logic [BITCNT_W-1:0] cnt;

  assign state = st;
  assign btn   = Rec_butt | Play_butt;
  assign wnext = wptr + 1'b1;
  assign rnext = rptr + 1'b1;

  // One counter serves both packing and unpacking: it is cleared on
  // record start and on each fetched word, and advances per strobe.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (st)
      IDLE:   cnt_clr = Rec_butt;
      RECORD: cnt_en  = bit_en & ~btn;
      FETCH:  cnt_clr = fetch_ph & ~btn;
      PLAY:   cnt_en  = bit_en & ~btn;
    endcase
  end

  packer_bit_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st            <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      rec_len       <= '0;
      full          <= 1'b0;
      shreg         <= '0;
      wr_pend       <= 1'b0;
      fetch_ph      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      bit_out       <= 1'b0;
      bit_out_valid <= 1'b0;
    end else begin
      mem_we        <= 1'b0;
      bit_out_valid <= 1'b0;
      unique case (st)
        IDLE: begin
          if (Rec_butt) begin
            st      <= RECORD;
            wptr    <= '0;
            full    <= 1'b0;
            wr_pend <= 1'b0;
          end else if (Play_butt && rec_len != '0) begin
            st       <= FETCH;
            rptr     <= '0;
            mem_addr <= '0;
            fetch_ph <= 1'b0;
          end
        end
        RECORD: begin
          if (btn) begin
            // Partial word and any not-yet-issued write are dropped.
            st      <= IDLE;
            rec_len <= wptr;
            wr_pend <= 1'b0;
          end else begin
            // Write is issued the cycle after the completing strobe,
            // so a reset in that cycle still suppresses it.
            if (wr_pend) begin
              wr_pend   <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= wptr[ADDR_W-1:0];
              mem_wdata <= shreg;
              wptr      <= wnext;
              if (wptr == LAST) begin
                full    <= 1'b1;
                rec_len <= DEPTH;
                st      <= IDLE;
              end
            end
            if (bit_en) begin
              shreg <= {shreg[WORD_W-2:0], bit_in};
              if (cnt == CNT_LAST) begin
                wr_pend <= 1'b1;
              end
            end
          end
        end
        FETCH: begin
          if (btn) begin
            st       <= IDLE;
            fetch_ph <= 1'b0;
          end else if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            shreg    <= mem_rdata;
            fetch_ph <= 1'b0;
            st       <= PLAY;
          end
        end
        PLAY: begin
          if (btn) begin
            st <= IDLE;
          end else if (bit_en) begin
            bit_out       <= shreg[WORD_W-1];
            bit_out_valid <= 1'b1;
            shreg         <= {shreg[WORD_W-2:0], 1'b0};
            if (cnt == CNT_LAST) begin
              fetch_ph <= 1'b0;
              if (rnext < rec_len) begin
                rptr     <= rnext;
                mem_addr <= rnext[ADDR_W-1:0];
                st       <= FETCH;
              end else begin
`ifdef PACKER_LOOP_PLAY_EN
                rptr     <= '0;
                mem_addr <= '0;
                st       <= FETCH;
`else
                rptr     <= rnext;
                st       <= IDLE;
`endif
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_playback_packer.sv
// Directed bench for record_playback_packer (ADDR_W=10 and ADDR_W=2).
// Honors PACKER_LOOP_PLAY_EN for the playback end-state check.
module tb_record_playback_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Rec_butt, Play_butt, rec2, play2;
  logic        bit_en, bit_in;

  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        bit_out, bit_out_valid, full;
  logic [1:0]  state;
  logic [10:0] rec_len;

  logic        mem_we2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2, mem_rdata2;
  logic        bit_out2, bit_out_valid2, full2;
  logic [1:0]  state2;
  logic [2:0]  rec_len2;

  logic [31:0] mem  [0:1023];
  logic [31:0] mem2 [0:3];
  int          wa[$], wa2[$];
  logic [31:0] wd[$], wd2[$];
  logic        bq[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  record_playback_packer #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .Rec_butt(Rec_butt), .Play_butt(Play_butt),
    .bit_en(bit_en), .bit_in(bit_in), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bit_out(bit_out), .bit_out_valid(bit_out_valid), .state(state),
    .rec_len(rec_len), .full(full)
  );

  record_playback_packer #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .Rec_butt(rec2), .Play_butt(play2),
    .bit_en(bit_en), .bit_in(bit_in), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .bit_out(bit_out2), .bit_out_valid(bit_out_valid2), .state(state2),
    .rec_len(rec_len2), .full(full2)
  );

  // Synchronous RAMs with one-cycle read latency plus write/bit logs.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wa.push_back(int'(mem_addr));
      wd.push_back(mem_wdata);
    end
    mem_rdata <= mem[mem_addr];
    if (bit_out_valid) bq.push_back(bit_out);
  end

  always @(posedge clk) begin
    if (mem_we2) begin
      mem2[mem_addr2] <= mem_wdata2;
      wa2.push_back(int'(mem_addr2));
      wd2.push_back(mem_wdata2);
    end
    mem_rdata2 <= mem2[mem_addr2];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    bit_in = b;
    step(1);
    bit_en = 1'b0;
    step(3);
  endtask

  task automatic press_rec();
    Rec_butt = 1'b1;
    step(1);
    Rec_butt = 1'b0;
  endtask

  task automatic press_play();
    Play_butt = 1'b1;
    step(1);
    Play_butt = 1'b0;
  endtask

  logic [31:0] exp_w;
  logic [31:0] exp4 [0:3];
  logic [31:0] pw0, pw1;
  logic [63:0] pexp;
  int          nwr, mism;

  initial begin
    reset = 1'b0; Rec_butt = 0; Play_butt = 0; rec2 = 0; play2 = 0;
    bit_en = 0; bit_in = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem2[i] = '0;
    step(2);

    // Reset values
    chk("rst_state", state, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_len", rec_len, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", bit_out_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_bout", bit_out, 0);
    reset = 1'b1;
    step(2);

    // 64 alternating bits -> two 0xAAAAAAAA words
    press_rec();
    chk("rec_state", state, 1);
    for (int i = 0; i < 64; i++) send_bit(i % 2 == 0);
    press_rec();
    chk("alt_state", state, 0);
    chk("alt_len", rec_len, 2);
    chk("alt_nwr", wa.size(), 2);
    chk("alt_a0", wa[0], 0);
    chk("alt_d0", wd[0], 32'hAAAAAAAA);
    chk("alt_a1", wa[1], 1);
    chk("alt_d1", wd[1], 32'hAAAAAAAA);

    // 40 bits -> one word, partial discarded
    wa.delete(); wd.delete();
    exp_w = '0;
    press_rec();
    for (int i = 0; i < 40; i++) begin
      if (i < 32) exp_w = {exp_w[30:0], 1'(i % 3 == 0)};
      send_bit(i % 3 == 0);
    end
    press_rec();
    step(4);
    chk("p40_nwr", wa.size(), 1);
    chk("p40_a0", wa[0], 0);
    chk("p40_d0", wd[0], exp_w);
    chk("p40_len", rec_len, 1);

    // Simultaneous buttons act as record; play with rec_len=0 ignored
    Rec_butt = 1'b1; Play_butt = 1'b1;
    step(1);
    Rec_butt = 1'b0; Play_butt = 1'b0;
    chk("both_state", state, 1);
    press_rec();
    chk("empty_len", rec_len, 0);
    press_play();
    chk("empty_play", state, 0);

    // ADDR_W=2: fill all four words, stop on exhaustion
    rec2 = 1'b1; step(1); rec2 = 1'b0;
    for (int i = 0; i < 128; i++) begin
      exp4[i/32] = {exp4[i/32][30:0], 1'((i % 7) < 3)};
      send_bit((i % 7) < 3);
    end
    chk("full_state", state2, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("full_flag", full2, 1);
    chk("full_len", rec_len2, 4);
    chk("full_nwr", wa2.size(), 4);
    chk("full_a0", wa2[0], 0);
    chk("full_a3", wa2[3], 3);
    chk("full_d1", wd2[1], exp4[1]);
    chk("full_d3", wd2[3], exp4[3]);
    chk("full_idle", state2, 0);

    // Playback of preloaded words
    press_rec();
    for (int i = 0; i < 64; i++) send_bit(1'b0);
    press_rec();
    chk("pb_len", rec_len, 2);
    mem[0] = 32'h80000001;
    mem[1] = 32'hFFFF0000;
    bq.delete();
    press_play();
    chk("pb_fetch0", state, 2);
    step(1);
    chk("pb_fetch1", state, 2);
    step(1);
    chk("pb_play", state, 3);
    bit_en = 1'b1;
    step(1);
    bit_en = 1'b0;
    chk("pb_v1", bit_out_valid, 1);
    chk("pb_b1", bit_out, 1);
    step(1);
    chk("pb_v0", bit_out_valid, 0);
    step(2);
    for (int i = 1; i < 63; i++) send_bit(1'b0);
    bit_en = 1'b1;
    step(1);
    bit_en = 1'b0;
`ifdef PACKER_LOOP_PLAY_EN
    chk("pb_end", state, 2);
    chk("pb_end_addr", mem_addr, 0);
`else
    chk("pb_end", state, 0);
`endif
    step(1);
    pw0 = 32'h80000001;
    pw1 = 32'hFFFF0000;
    pexp = {pw0, pw1};
    chk("pb_nbits", bq.size(), 64);
    mism = 0;
    for (int i = 0; i < 64 && i < bq.size(); i++)
      if (bq[i] !== pexp[63-i]) mism++;
    chk("pb_bits", mism, 0);

    // A button during fetch/play aborts and keeps rec_len
`ifndef PACKER_LOOP_PLAY_EN
    press_play();
`endif
    step(1);
    press_play();
    chk("abort_state", state, 0);
    chk("abort_len", rec_len, 2);

    // Reset right after the 32nd strobe suppresses the write
    wa.delete(); wd.delete();
    press_rec();
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    bit_en = 1'b1; bit_in = 1'b1;
    step(1);
    bit_en = 1'b0;
    reset = 1'b0;
    chk("r43_we_pre", mem_we, 0);
    step(1);
    chk("r43_we", mem_we, 0);
    chk("r43_state", state, 0);
    chk("r43_len", rec_len, 0);
    chk("r43_wdata", mem_wdata, 0);
    chk("r43_addr", mem_addr, 0);
    chk("r43_valid", bit_out_valid, 0);
    reset = 1'b1;
    step(4);
    nwr = wa.size();
    chk("r43_nwr", nwr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
